// File: rtl/if_stage_pkg.sv
//------------------------------------------------------------------------------
// Module  : if_stage_pkg
// Brief   : Shared width, NOP encoding and fetch FSM state encoding.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package if_stage_pkg;
  localparam int WORD_LEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_HOLD = 2'd1,
    ST_DROP = 2'd2
  } state_t;
endpackage

`default_nettype wire

// File: rtl/if_stage_pc_register.sv
//------------------------------------------------------------------------------
// Module  : pc_register
// Brief   : Load-enabled address register, asynchronous active-low reset.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pc_register #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    q <= RESET_VAL;
    else if (en) q <= d;
  end

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
//------------------------------------------------------------------------------
// Module  : if_stage
// Brief   : MIPS instruction fetch with req/ack memory port, freeze hold and
//           branch redirect (including redirect of an outstanding request).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module if_stage #(
  parameter int                  WORD_LEN = if_stage_pkg::WORD_LEN,
  parameter logic [WORD_LEN-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                branch_taken,
  input  logic [WORD_LEN-1:0] branch_target,
  output logic                imem_req,
  output logic [WORD_LEN-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [WORD_LEN-1:0] imem_rdata,
  output logic [WORD_LEN-1:0] PCplus4,
  output logic [WORD_LEN-1:0] instruction,
  output logic                if_valid,
  output logic                flush
);
  import if_stage_pkg::*;

  localparam logic [WORD_LEN-1:0] C_NOP  = WORD_LEN'(NOP_INSTR);
  localparam logic [WORD_LEN-1:0] C_FOUR = WORD_LEN'(4);

  state_t              r_state, w_state_nxt;
  logic [WORD_LEN-1:0] r_pc, r_hold_inst, r_hold_pc4;
  logic [WORD_LEN-1:0] w_req_addr, w_req_addr_nxt, w_seq, w_target;
  logic                w_req_en, w_pc_en, w_hold_en;
  logic                w_req, w_valid;
  logic [WORD_LEN-1:0] w_inst, w_pc4;

  assign w_target = {branch_target[WORD_LEN-1:2], 2'b00};
  assign w_seq    = w_req_addr + C_FOUR;

  pc_register #(
    .WIDTH     (WORD_LEN),
    .RESET_VAL (RESET_PC)
  ) u_req_addr (
    .clk (clk),
    .rst (rst),
    .en  (w_req_en),
    .d   (w_req_addr_nxt),
    .q   (w_req_addr)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_REQ;
      r_pc        <= RESET_PC;
      r_hold_inst <= '0;
      r_hold_pc4  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pc_en) r_pc <= w_target;
      if (w_hold_en) begin
        r_hold_inst <= imem_rdata;
        r_hold_pc4  <= w_seq;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_req_en       = 1'b0;
    w_req_addr_nxt = w_seq;
    w_pc_en        = 1'b0;
    w_hold_en      = 1'b0;
    w_req          = 1'b0;
    w_valid        = 1'b0;
    w_inst         = C_NOP;
    w_pc4          = '0;
    case (r_state)
      ST_REQ: begin
        w_req = 1'b1;
        if (branch_taken) begin
          if (imem_ack) begin
            w_req_en       = 1'b1;
            w_req_addr_nxt = w_target;
          end else begin
            // Request cannot be withdrawn; park the target until it completes.
            w_pc_en     = 1'b1;
            w_state_nxt = ST_DROP;
          end
        end else if (imem_ack) begin
          w_valid  = 1'b1;
          w_inst   = imem_rdata;
          w_pc4    = w_seq;
          w_req_en = 1'b1;
          if (freeze) begin
            w_hold_en   = 1'b1;
            w_state_nxt = ST_HOLD;
          end
        end
      end
      ST_DROP: begin
        w_req = 1'b1;
        if (branch_taken) w_pc_en = 1'b1;
        if (imem_ack) begin
          w_req_en       = 1'b1;
          w_req_addr_nxt = branch_taken ? w_target : r_pc;
          w_state_nxt    = ST_REQ;
        end
      end
      ST_HOLD: begin
        if (branch_taken) begin
          w_req_en       = 1'b1;
          w_req_addr_nxt = w_target;
          w_state_nxt    = ST_REQ;
        end else begin
          w_valid = 1'b1;
          w_inst  = r_hold_inst;
          w_pc4   = r_hold_pc4;
          if (!freeze) w_state_nxt = ST_REQ;
        end
      end
      default: w_state_nxt = ST_REQ;
    endcase
  end

  assign imem_req    = w_req & rst;
  assign imem_addr   = w_req_addr;
  assign if_valid    = w_valid & rst;
  assign instruction = rst ? w_inst : C_NOP;
  assign PCplus4     = rst ? w_pc4 : '0;
  assign flush       = branch_taken;

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a stub memory of programmable wait states.
`default_nettype none

module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] PCplus4;
  logic [31:0] instruction;
  logic        if_valid;
  logic        flush;

  int total = 0;
  int bad   = 0;
  int waits;
  int cnt;

  always #5 clk = ~clk;

  if_stage #(.WORD_LEN(32), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .rst           (rst),
    .freeze        (freeze),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .PCplus4       (PCplus4),
    .instruction   (instruction),
    .if_valid      (if_valid),
    .flush         (flush)
  );

  // Memory stub: ack after 'waits' extra cycles; data is the inverted address.
  assign imem_ack   = imem_req && (cnt == waits);
  assign imem_rdata = ~imem_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       cnt <= 0;
    else if (!imem_req || imem_ack) cnt <= 0;
    else                            cnt <= cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_target = 32'h0; waits = 0;
    step(); step();
    chk("rst_req",   {31'b0, imem_req}, 32'h0);
    chk("rst_valid", {31'b0, if_valid}, 32'h0);
    chk("rst_inst",  instruction,       32'h0);
    chk("rst_pc4",   PCplus4,           32'h0);
    chk("rst_addr",  imem_addr,         32'h0);
    chk("rst_flush", {31'b0, flush},    32'h0);

    // Zero-wait sequential fetch
    rst = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      chk("zw_req",   {31'b0, imem_req}, 32'h1);
      chk("zw_addr",  imem_addr,         32'(i * 4));
      chk("zw_valid", {31'b0, if_valid}, 32'h1);
      chk("zw_pc4",   PCplus4,           32'(i * 4 + 4));
      chk("zw_inst",  instruction,       ~32'(i * 4));
      step();
    end

    // Two-wait memory from 0x10
    waits = 2; #1;
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 3; j++) begin
        chk("w2_addr",  imem_addr,               32'h10 + 32'(k * 4));
        chk("w2_valid", {31'b0, if_valid},       (j == 2) ? 32'h1 : 32'h0);
        chk("w2_inst",  instruction,             (j == 2) ? ~(32'h10 + 32'(k * 4)) : 32'h0);
        chk("w2_pc4",   PCplus4,                 (j == 2) ? 32'h14 + 32'(k * 4) : 32'h0);
        step();
      end
    end

    // Branch while request to 0x18 is pending
    branch_taken = 1'b1; branch_target = 32'h41; #1;
    chk("br_flush", {31'b0, flush},    32'h1);
    chk("br_valid", {31'b0, if_valid}, 32'h0);
    chk("br_inst",  instruction,       32'h0);
    chk("br_addr",  imem_addr,         32'h18);
    step(); branch_taken = 1'b0; #1;
    chk("drop1_addr",  imem_addr,         32'h18);
    chk("drop1_req",   {31'b0, imem_req}, 32'h1);
    chk("drop1_flush", {31'b0, flush},    32'h0);
    step();
    chk("drop2_ack",   {31'b0, imem_ack}, 32'h1);
    chk("drop2_addr",  imem_addr,         32'h18);
    chk("drop2_valid", {31'b0, if_valid}, 32'h0);
    chk("drop2_inst",  instruction,       32'h0);
    step();
    chk("tgt_addr",  imem_addr,         32'h40);
    chk("tgt_valid", {31'b0, if_valid}, 32'h0);
    step(); step();
    chk("tgt_valid2", {31'b0, if_valid}, 32'h1);
    chk("tgt_inst",   instruction,       32'hFFFF_FFBF);
    chk("tgt_pc4",    PCplus4,           32'h44);
    step();
    chk("seq_addr", imem_addr, 32'h44);

    // Zero-wait branch with ack to 0x8, then freeze on its ack
    waits = 0; branch_taken = 1'b1; branch_target = 32'h8; #1;
    chk("bra_valid", {31'b0, if_valid}, 32'h0);
    chk("bra_inst",  instruction,       32'h0);
    chk("bra_flush", {31'b0, flush},    32'h1);
    step(); branch_taken = 1'b0; freeze = 1'b1; #1;
    chk("fz_addr",  imem_addr,         32'h8);
    chk("fz_valid", {31'b0, if_valid}, 32'h1);
    chk("fz_pc4",   PCplus4,           32'hC);
    chk("fz_inst",  instruction,       32'hFFFF_FFF7);
    for (int h = 0; h < 2; h++) begin
      step();
      chk("hold_req",   {31'b0, imem_req}, 32'h0);
      chk("hold_valid", {31'b0, if_valid}, 32'h1);
      chk("hold_pc4",   PCplus4,           32'hC);
      chk("hold_inst",  instruction,       32'hFFFF_FFF7);
    end
    step(); freeze = 1'b0; #1;
    chk("rel_req",   {31'b0, imem_req}, 32'h0);
    chk("rel_valid", {31'b0, if_valid}, 32'h1);
    chk("rel_pc4",   PCplus4,           32'hC);
    step();
    chk("after_req",  {31'b0, imem_req}, 32'h1);
    chk("after_addr", imem_addr,         32'hC);
    chk("after_pc4",  PCplus4,           32'h10);

    // Wrap-around
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC; #1;
    chk("wbr_valid", {31'b0, if_valid}, 32'h0);
    step(); branch_taken = 1'b0; #1;
    chk("wrap_addr",  imem_addr,         32'hFFFF_FFFC);
    chk("wrap_pc4",   PCplus4,           32'h0);
    chk("wrap_inst",  instruction,       32'h3);
    chk("wrap_valid", {31'b0, if_valid}, 32'h1);
    step();
    chk("wrap_next_addr", imem_addr, 32'h0);
    chk("wrap_next_pc4",  PCplus4,   32'h4);

    // Reset in the middle of HOLD
    freeze = 1'b1; #1;
    step();
    chk("h2_req",  {31'b0, imem_req}, 32'h0);
    chk("h2_pc4",  PCplus4,           32'h4);
    chk("h2_inst", instruction,       32'hFFFF_FFFF);
    #2 rst = 1'b0; #1;
    chk("arst_valid", {31'b0, if_valid}, 32'h0);
    chk("arst_inst",  instruction,       32'h0);
    chk("arst_pc4",   PCplus4,           32'h0);
    chk("arst_req",   {31'b0, imem_req}, 32'h0);
    step(); step();
    rst = 1'b1; freeze = 1'b0; #1;
    chk("restart_req",   {31'b0, imem_req}, 32'h1);
    chk("restart_addr",  imem_addr,         32'h0);
    chk("restart_valid", {31'b0, if_valid}, 32'h1);
    chk("restart_pc4",   PCplus4,           32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
